conv_loop_sequencer: RTL and testbench

Single-clock, runtime-configurable loop-nest sequencer for the convolution dataflow. It generates the (W_H, W_W, I_CH tile, O_CH tile, O_H) iteration sequence and produces matching weight and IFMap SRAM addresses. Back-pressure is handled with a valid/ready step handshake. It replaces the chain of counters clocked from each other's `isNext` pulses, and sits between the top-level start logic and the Weight/IFMap SRAM read ports.

---
 rtl/conv_seq_pkg.sv | 25 ++
 rtl/loop_counter.sv | 43 ++++
 rtl/conv_loop_sequencer.sv | 170 +++++++++++++++++
 tb/tb_conv_loop_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_seq_pkg.sv
// Shared types and helpers for the convolution loop-nest sequencer.
// Holds the sequencer state encoding plus small arithmetic helpers used by the top level.
package conv_seq_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

    // A programmed bound of zero still means one iteration.
    function automatic logic [31:0] clamp1(input logic [31:0] x);
        return (x == 32'd0) ? 32'd1 : x;
    endfunction

    // Linear weight-tile index; bounds are passed as counts, not maxima.
    function automatic logic [31:0] tile_index(
        input logic [31:0] w_h,
        input logic [31:0] w_w,  input logic [31:0] w_w_bound,
        input logic [31:0] i_ch, input logic [31:0] i_ch_bound,
        input logic [31:0] o_ch, input logic [31:0] o_ch_bound
    );
        return ((w_h * w_w_bound + w_w) * i_ch_bound + i_ch) * o_ch_bound + o_ch;
    endfunction

endpackage

// File: rtl/loop_counter.sv
// Wrapping counter for one level of the loop nest: counts 0..max, wraps on inc at max.
// Exposes its next value so the parent can register values derived from it with zero skew.
module loop_counter #(
    parameter int CNT_BIT = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               inc,
    input  logic               clr,
    input  logic [CNT_BIT-1:0] max,
    output logic [CNT_BIT-1:0] count,
    output logic [CNT_BIT-1:0] count_nxt,
    output logic               at_max
);

    logic [CNT_BIT-1:0] count_q;
    logic [CNT_BIT-1:0] count_d;

    assign at_max = (count_q == max);

    // NOTE: default assignment first so every path writes count_d and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = at_max ? '0 : count_q + 1'b1;
        end
    end

    // NOTE: non-blocking assignment for state so all flops update together at the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign count_nxt = count_d;

endmodule

// File: rtl/conv_loop_sequencer.sv
// Five-level loop-nest sequencer (O_H innermost .. W_H outermost) with valid/ready stepping.
// Produces weight-tile and IFMap row addresses registered alongside the indices they belong to.
module conv_loop_sequencer
    import conv_seq_pkg::*;
#(
    parameter int MAC_ROW        = 16,
    parameter int MAC_COL        = 16,
    parameter int W_ADDR_BIT     = 11,
    parameter int IFMAP_ADDR_BIT = 9,
    parameter int CNT_BIT        = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start_in,
    input  logic                      abort_in,
    input  logic [CNT_BIT-1:0]        cfg_o_h,
    input  logic [CNT_BIT-1:0]        cfg_o_ch_tiles,
    input  logic [CNT_BIT-1:0]        cfg_i_ch_tiles,
    input  logic [CNT_BIT-1:0]        cfg_w_w,
    input  logic [CNT_BIT-1:0]        cfg_w_h,
    input  logic [CNT_BIT-1:0]        cfg_ifmap_h,
    input  logic [1:0]                cfg_stride,
    output logic                      step_valid_out,
    input  logic                      step_ready_in,
    output logic [CNT_BIT-1:0]        o_h_count_out,
    output logic [CNT_BIT-1:0]        o_ch_count_out,
    output logic [CNT_BIT-1:0]        i_ch_count_out,
    output logic [CNT_BIT-1:0]        w_w_count_out,
    output logic [CNT_BIT-1:0]        w_h_count_out,
    output logic [W_ADDR_BIT-1:0]     w_addr_out,
    output logic [IFMAP_ADDR_BIT-1:0] ifmap_addr_out,
    output logic                      w_prefetch_out,
    output logic                      last_out,
    output logic                      busy_out,
    output logic                      done_out
);

    if (MAC_COL < 1) begin : g_bad_mac_col
        $error("MAC_COL must be at least 1");
    end

    seq_state_t state_q, state_d;
    logic [CNT_BIT-1:0] oh_max_q, oh_max_d, oc_max_q, oc_max_d, ic_max_q, ic_max_d;
    logic [CNT_BIT-1:0] ww_max_q, ww_max_d, wh_max_q, wh_max_d;
    logic [CNT_BIT-1:0] ifmap_h_q, ifmap_h_d;
    logic [1:0]         stride_q, stride_d;
    logic [W_ADDR_BIT-1:0]     w_addr_q, w_addr_d;
    logic [IFMAP_ADDR_BIT-1:0] ifmap_addr_q, ifmap_addr_d;
    logic prefetch_q, prefetch_d, last_q, last_d, done_q, done_d;

    logic [CNT_BIT-1:0] oh_cnt, oc_cnt, ic_cnt, ww_cnt, wh_cnt;
    logic [CNT_BIT-1:0] oh_nxt, oc_nxt, ic_nxt, ww_nxt, wh_nxt;
    logic oh_at_max, oc_at_max, ic_at_max, ww_at_max, wh_at_max;
    logic run, fire, abort, start_acc, finish, cnt_clr, run_d;
    logic inc_oh, inc_oc, inc_ic, inc_ww, inc_wh;

    assign run       = (state_q == ST_RUN);
    assign fire      = run & step_ready_in;
    assign abort     = run & abort_in;
    assign start_acc = ~run & start_in;
    // Abort beats a simultaneous handshake, including on the final step.
    assign finish    = fire & ~abort_in & oh_at_max & oc_at_max & ic_at_max & ww_at_max & wh_at_max;
    assign cnt_clr   = start_acc | abort | finish;

    assign inc_oh = fire & ~abort_in;
    assign inc_oc = inc_oh & oh_at_max;
    assign inc_ic = inc_oc & oc_at_max;
    assign inc_ww = inc_ic & ic_at_max;
    assign inc_wh = inc_ww & ww_at_max;

    loop_counter #(.CNT_BIT(CNT_BIT)) u_oh (
        .clk(clk), .rstn(rstn), .inc(inc_oh), .clr(cnt_clr), .max(oh_max_q),
        .count(oh_cnt), .count_nxt(oh_nxt), .at_max(oh_at_max)
    );
    loop_counter #(.CNT_BIT(CNT_BIT)) u_oc (
        .clk(clk), .rstn(rstn), .inc(inc_oc), .clr(cnt_clr), .max(oc_max_q),
        .count(oc_cnt), .count_nxt(oc_nxt), .at_max(oc_at_max)
    );
    loop_counter #(.CNT_BIT(CNT_BIT)) u_ic (
        .clk(clk), .rstn(rstn), .inc(inc_ic), .clr(cnt_clr), .max(ic_max_q),
        .count(ic_cnt), .count_nxt(ic_nxt), .at_max(ic_at_max)
    );
    loop_counter #(.CNT_BIT(CNT_BIT)) u_ww (
        .clk(clk), .rstn(rstn), .inc(inc_ww), .clr(cnt_clr), .max(ww_max_q),
        .count(ww_cnt), .count_nxt(ww_nxt), .at_max(ww_at_max)
    );
    loop_counter #(.CNT_BIT(CNT_BIT)) u_wh (
        .clk(clk), .rstn(rstn), .inc(inc_wh), .clr(cnt_clr), .max(wh_max_q),
        .count(wh_cnt), .count_nxt(wh_nxt), .at_max(wh_at_max)
    );

    always_comb begin
        state_d = state_q;
        if (start_acc) begin
            state_d = ST_RUN;
        end else if (abort | finish) begin
            state_d = ST_IDLE;
        end
        run_d = (state_d == ST_RUN);

        // Bounds are held as maxima (bound-1) so the counters compare directly.
        oh_max_d  = start_acc ? CNT_BIT'(clamp1(32'(cfg_o_h))        - 32'd1) : oh_max_q;
        oc_max_d  = start_acc ? CNT_BIT'(clamp1(32'(cfg_o_ch_tiles)) - 32'd1) : oc_max_q;
        ic_max_d  = start_acc ? CNT_BIT'(clamp1(32'(cfg_i_ch_tiles)) - 32'd1) : ic_max_q;
        ww_max_d  = start_acc ? CNT_BIT'(clamp1(32'(cfg_w_w))        - 32'd1) : ww_max_q;
        wh_max_d  = start_acc ? CNT_BIT'(clamp1(32'(cfg_w_h))        - 32'd1) : wh_max_q;
        ifmap_h_d = start_acc ? cfg_ifmap_h : ifmap_h_q;
        stride_d  = start_acc ? 2'(clamp1(32'(cfg_stride))) : stride_q;

        // Addresses are built from next-cycle indices so they land with them.
        w_addr_d = W_ADDR_BIT'(tile_index(32'(wh_nxt),
                                          32'(ww_nxt), 32'(ww_max_d) + 32'd1,
                                          32'(ic_nxt), 32'(ic_max_d) + 32'd1,
                                          32'(oc_nxt), 32'(oc_max_d) + 32'd1) * 32'(MAC_ROW));
        ifmap_addr_d = IFMAP_ADDR_BIT'(32'(ic_nxt) * 32'(ifmap_h_d)
                                     + 32'(oh_nxt) * 32'(stride_d)
                                     + 32'(wh_nxt));

        prefetch_d = run_d & (oh_nxt == '0);
        last_d     = run_d & (oh_nxt == oh_max_d) & (oc_nxt == oc_max_d) & (ic_nxt == ic_max_d)
                           & (ww_nxt == ww_max_d) & (wh_nxt == wh_max_d);
        done_d     = finish;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            oh_max_q     <= '0;
            oc_max_q     <= '0;
            ic_max_q     <= '0;
            ww_max_q     <= '0;
            wh_max_q     <= '0;
            ifmap_h_q    <= '0;
            stride_q     <= '0;
            w_addr_q     <= '0;
            ifmap_addr_q <= '0;
            prefetch_q   <= 1'b0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            oh_max_q     <= oh_max_d;
            oc_max_q     <= oc_max_d;
            ic_max_q     <= ic_max_d;
            ww_max_q     <= ww_max_d;
            wh_max_q     <= wh_max_d;
            ifmap_h_q    <= ifmap_h_d;
            stride_q     <= stride_d;
            w_addr_q     <= w_addr_d;
            ifmap_addr_q <= ifmap_addr_d;
            prefetch_q   <= prefetch_d;
            last_q       <= last_d;
            done_q       <= done_d;
        end
    end

    assign step_valid_out = run;
    assign busy_out       = run;
    assign o_h_count_out  = oh_cnt;
    assign o_ch_count_out = oc_cnt;
    assign i_ch_count_out = ic_cnt;
    assign w_w_count_out  = ww_cnt;
    assign w_h_count_out  = wh_cnt;
    assign w_addr_out     = w_addr_q;
    assign ifmap_addr_out = ifmap_addr_q;
    assign w_prefetch_out = prefetch_q;
    assign last_out       = last_q;
    assign done_out       = done_q;

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Directed self-checking bench for conv_loop_sequencer with a small loop-nest reference model.
module tb_conv_loop_sequencer;

    localparam int CNT_BIT        = 8;
    localparam int W_ADDR_BIT     = 11;
    localparam int IFMAP_ADDR_BIT = 9;
    localparam int MAC_ROW        = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start_in = 1'b0, abort_in = 1'b0, step_ready_in = 1'b0;
    logic [CNT_BIT-1:0] cfg_o_h = '0, cfg_o_ch_tiles = '0, cfg_i_ch_tiles = '0;
    logic [CNT_BIT-1:0] cfg_w_w = '0, cfg_w_h = '0, cfg_ifmap_h = '0;
    logic [1:0] cfg_stride = '0;
    logic step_valid_out, w_prefetch_out, last_out, busy_out, done_out;
    logic [CNT_BIT-1:0] o_h_count_out, o_ch_count_out, i_ch_count_out, w_w_count_out, w_h_count_out;
    logic [W_ADDR_BIT-1:0] w_addr_out;
    logic [IFMAP_ADDR_BIT-1:0] ifmap_addr_out;

    conv_loop_sequencer #(
        .MAC_ROW(MAC_ROW), .MAC_COL(16), .W_ADDR_BIT(W_ADDR_BIT),
        .IFMAP_ADDR_BIT(IFMAP_ADDR_BIT), .CNT_BIT(CNT_BIT)
    ) dut (
        .clk(clk), .rstn(rstn), .start_in(start_in), .abort_in(abort_in),
        .cfg_o_h(cfg_o_h), .cfg_o_ch_tiles(cfg_o_ch_tiles), .cfg_i_ch_tiles(cfg_i_ch_tiles),
        .cfg_w_w(cfg_w_w), .cfg_w_h(cfg_w_h), .cfg_ifmap_h(cfg_ifmap_h), .cfg_stride(cfg_stride),
        .step_valid_out(step_valid_out), .step_ready_in(step_ready_in),
        .o_h_count_out(o_h_count_out), .o_ch_count_out(o_ch_count_out),
        .i_ch_count_out(i_ch_count_out), .w_w_count_out(w_w_count_out),
        .w_h_count_out(w_h_count_out), .w_addr_out(w_addr_out), .ifmap_addr_out(ifmap_addr_out),
        .w_prefetch_out(w_prefetch_out), .last_out(last_out), .busy_out(busy_out),
        .done_out(done_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int oh, oc, ic, ww, wh, wa, ia, pf, last;
    } step_t;

    int checks = 0;
    int errors = 0;
    int b_oh = 1, b_ot = 1, b_it = 1, b_ww = 1, b_wh = 1, b_ifh = 0, b_st = 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic step_t model(input int k);
        step_t e;
        int r = k;
        int tile;
        e.oh = r % b_oh; r = r / b_oh;
        e.oc = r % b_ot; r = r / b_ot;
        e.ic = r % b_it; r = r / b_it;
        e.ww = r % b_ww; r = r / b_ww;
        e.wh = r;
        tile = ((e.wh * b_ww + e.ww) * b_it + e.ic) * b_ot + e.oc;
        e.wa = (tile * MAC_ROW) % (1 << W_ADDR_BIT);
        e.ia = (e.ic * b_ifh + e.oh * b_st + e.wh) % (1 << IFMAP_ADDR_BIT);
        e.pf = (e.oh == 0) ? 1 : 0;
        e.last = (k == b_oh * b_ot * b_it * b_ww * b_wh - 1) ? 1 : 0;
        return e;
    endfunction

    function automatic step_t observe();
        step_t o;
        o.oh = int'(o_h_count_out);  o.oc = int'(o_ch_count_out);
        o.ic = int'(i_ch_count_out); o.ww = int'(w_w_count_out);
        o.wh = int'(w_h_count_out);  o.wa = int'(w_addr_out);
        o.ia = int'(ifmap_addr_out); o.pf = int'(w_prefetch_out);
        o.last = int'(last_out);
        return o;
    endfunction

    // Drives the config, pulses start for one edge, returns #1 after that edge.
    task automatic do_start(input int oh, input int ot, input int it, input int ww,
                            input int wh, input int ifh, input int st);
        cfg_o_h = CNT_BIT'(oh);  cfg_o_ch_tiles = CNT_BIT'(ot); cfg_i_ch_tiles = CNT_BIT'(it);
        cfg_w_w = CNT_BIT'(ww);  cfg_w_h = CNT_BIT'(wh);        cfg_ifmap_h = CNT_BIT'(ifh);
        cfg_stride = 2'(st);
        b_oh = (oh == 0) ? 1 : oh; b_ot = (ot == 0) ? 1 : ot; b_it = (it == 0) ? 1 : it;
        b_ww = (ww == 0) ? 1 : ww; b_wh = (wh == 0) ? 1 : wh;
        b_ifh = ifh; b_st = (st == 0) ? 1 : st;
        start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
    endtask

    // Walks the sequence, comparing every presented step against the model.
    task automatic run_steps(input int total, input bit rnd, input int stop_k, input int probe_k,
                             output int seq_errs, output int k, output int last_at,
                             output step_t probe);
        int cyc = 0;
        bit rdy;
        step_t e, o;
        seq_errs = 0; k = 0; last_at = -1;
        probe = '{default: 0};
        while (k < total && k != stop_k && cyc < 6000) begin
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step_ready_in = rdy;
            if (rnd) begin
                start_in = ((cyc % 37) == 5);
                cfg_o_h  = CNT_BIT'($urandom);
            end
            if (!step_valid_out || done_out || !busy_out) begin
                seq_errs++;
            end else begin
                e = model(k);
                o = observe();
                if (o != e) seq_errs++;
                if (last_out && last_at < 0) last_at = k;
                if (k == probe_k) probe = o;
                if (rdy) k++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_in = 1'b0;
    endtask

    initial begin
        int se, k, la;
        step_t pr;

        #3;
        check("rst_valid", 32'(step_valid_out), 32'd0);
        check("rst_done", 32'(done_out), 32'd0);
        #9 rstn = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", 32'(busy_out), 32'd0);
        check("idle_waddr", 32'(w_addr_out), 32'd0);
        check("idle_prefetch", 32'(w_prefetch_out), 32'd0);

        // 14 x 4 x 2 x 3 x 3 = 1008 steps, ready held high.
        do_start(14, 4, 2, 3, 3, 20, 1);
        check("first_valid", 32'(step_valid_out), 32'd1);
        check("first_waddr", 32'(w_addr_out), 32'd0);
        check("first_ifmap", 32'(ifmap_addr_out), 32'd0);
        check("first_prefetch", 32'(w_prefetch_out), 32'd1);
        run_steps(1008, 1'b0, -1, 14, se, k, la, pr);
        check("run1_seq", 32'(se), 32'd0);
        check("run1_steps", 32'(k), 32'd1008);
        check("run1_last_at", 32'(la), 32'd1007);
        check("run1_step14_och", 32'(pr.oc), 32'd1);
        check("run1_step14_waddr", 32'(pr.wa), 32'd16);
        check("run1_end_valid", 32'(step_valid_out), 32'd0);
        check("run1_done", 32'(done_out), 32'd1);
        step_ready_in = 1'b0;

        // Restart during the done cycle; random ready, stray start pulses, cfg churn.
        do_start(14, 4, 2, 3, 3, 20, 1);
        check("restart_done_low", 32'(done_out), 32'd0);
        check("restart_valid", 32'(step_valid_out), 32'd1);
        run_steps(1008, 1'b1, -1, 500, se, k, la, pr);
        check("rnd_seq", 32'(se), 32'd0);
        check("rnd_steps", 32'(k), 32'd1008);
        check("rnd_last_at", 32'(la), 32'd1007);
        check("rnd_step500_waddr", 32'(pr.wa), 32'd560);
        check("rnd_step500_ifmap", 32'(pr.ia), 32'd11);
        check("rnd_done", 32'(done_out), 32'd1);
        step_ready_in = 1'b0;
        @(posedge clk); #1;
        check("rnd_done_pulse", 32'(done_out), 32'd0);

        // ifmap_h 16, stride 2: (i_ch 1, o_h 3, w_h 2) is the final step, index 23.
        do_start(4, 1, 2, 1, 3, 16, 2);
        run_steps(24, 1'b0, -1, 23, se, k, la, pr);
        check("stride_seq", 32'(se), 32'd0);
        check("stride_ifmap", 32'(pr.ia), 32'd24);
        check("stride_waddr", 32'(pr.wa), 32'd80);
        check("stride_last_at", 32'(la), 32'd23);
        step_ready_in = 1'b0;
        @(posedge clk); #1;

        // All bounds zero: a single step.
        do_start(0, 0, 0, 0, 0, 0, 0);
        check("zero_last", 32'(last_out), 32'd1);
        check("zero_prefetch", 32'(w_prefetch_out), 32'd1);
        run_steps(1, 1'b0, -1, -1, se, k, la, pr);
        check("zero_steps", 32'(k), 32'd1);
        check("zero_done", 32'(done_out), 32'd1);
        check("zero_valid", 32'(step_valid_out), 32'd0);
        step_ready_in = 1'b0;
        @(posedge clk); #1;

        // Abort together with a handshake at step 50.
        do_start(14, 4, 2, 3, 3, 20, 1);
        run_steps(1008, 1'b0, 50, -1, se, k, la, pr);
        check("abort_reach", 32'(k), 32'd50);
        check("abort_pre_waddr", 32'(w_addr_out), 32'd48);
        abort_in = 1'b1; step_ready_in = 1'b1;
        @(posedge clk); #1;
        abort_in = 1'b0; step_ready_in = 1'b0;
        check("abort_valid", 32'(step_valid_out), 32'd0);
        check("abort_done", 32'(done_out), 32'd0);
        check("abort_oh", 32'(o_h_count_out), 32'd0);
        check("abort_waddr", 32'(w_addr_out), 32'd0);
        @(posedge clk); #1;
        check("abort_no_done", 32'(done_out), 32'd0);

        // Start and abort together in IDLE: start wins, step 0 is reproduced.
        abort_in = 1'b1;
        do_start(14, 4, 2, 3, 3, 20, 1);
        abort_in = 1'b0;
        check("sa_valid", 32'(step_valid_out), 32'd1);
        check("sa_oh", 32'(o_h_count_out), 32'd0);
        check("sa_ifmap", 32'(ifmap_addr_out), 32'd0);
        check("sa_prefetch", 32'(w_prefetch_out), 32'd1);

        // Asynchronous reset mid-run at step 20 (o_h 6, o_ch 1).
        run_steps(1008, 1'b0, 20, -1, se, k, la, pr);
        check("mid_seq", 32'(se), 32'd0);
        check("mid_pre_ifmap", 32'(ifmap_addr_out), 32'd6);
        step_ready_in = 1'b0;
        rstn = 1'b0;
        #1;
        check("arst_valid", 32'(step_valid_out), 32'd0);
        check("arst_busy", 32'(busy_out), 32'd0);
        check("arst_waddr", 32'(w_addr_out), 32'd0);
        check("arst_ifmap", 32'(ifmap_addr_out), 32'd0);
        check("arst_oh", 32'(o_h_count_out), 32'd0);
        check("arst_och", 32'(o_ch_count_out), 32'd0);
        check("arst_prefetch", 32'(w_prefetch_out), 32'd0);
        #2 rstn = 1'b1;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
